regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//  Shares one 32:1 register-file read port (mux32by1 bit slices, 5-bit sel) among
//  NUM_REQ requesters, e.g. decode rs1/rs2, store-data read and debug read.
//  Grants one requester per cycle by round-robin, drives the mux select, and
//  registers the returned data as a tagged response one cycle later.
//  Sits between decode/debug logic and the register file bit-slice mux array.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  ADDR_W    5   register index width (drives mux sel)
//  DATA_W    64  register width (one mux32by1 per bit)
//  ZERO_IDX  31  index that always reads as zero (XZR)
// PORTS
//  clk        in   1                clock, all state on rising edge
//  reset      in   1                synchronous, active-high
//  stall      in   1                pipeline stall; blocks new grants
//  req        in   NUM_REQ          per-requester read request, held until granted
//  req_addr   in   NUM_REQ*ADDR_W   register index per requester, slot i at [i*ADDR_W +: ADDR_W]
//  gnt        out  NUM_REQ          one-hot grant, combinational, same cycle as req
//  rd_sel     out  ADDR_W           select to mux array = req_addr of granted slot, else 0
//  rd_data    in   DATA_W           mux array output for rd_sel (combinational path)
//  rsp_valid  out  1                registered response valid
//  rsp_id     out  $clog2(NUM_REQ)  index of requester owning rsp_data
//  rsp_data   out  DATA_W           registered read data
// BEHAVIOUR
//  Reset (sync, high): rr_ptr<=0, rsp_valid<=0, rsp_id<=0, rsp_data<=0; gnt=0 while reset high.
//  Arbitration (comb): if stall or req==0 -> gnt=0, rd_sel=0. Else grant first set
//   req bit searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0. Exactly one gnt bit.
//  rr_ptr: on any grant to slot g, rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1; else holds.
//  Handshake: requester sees gnt[i] in cycle T, drops or changes req/addr at T+1.
//   req held without grant must not change req_addr (assertion in bench).
//  Latency: grant in cycle T -> rsp_valid=1, rsp_id=g, rsp_data at T+1 for exactly
//   one cycle; back-to-back grants give back-to-back responses (1 read/cycle).
//  Zero register: if granted addr == ZERO_IDX, rsp_data <= 0 regardless of rd_data.
//  No grant in cycle T -> rsp_valid=0 at T+1; rsp_id/rsp_data hold previous values.
//  stall high: no grant, rr_ptr holds; response from the pre-stall grant still issues.
//  Reset mid-operation: pending requests dropped, response for grant in reset cycle
//   suppressed (rsp_valid=0 after reset), fairness restarts at slot 0.
//  Single requester asserted continuously: granted every cycle (no idle bubbles).
//  Width rule: rd_sel is exactly ADDR_W bits; indices >= 2**ADDR_W not possible.
// STRUCTURE
//  Package regfile_pkg: ADDR_W, DATA_W, ZERO_IDX constants; typedef reg_idx_t
//   (logic [ADDR_W-1:0]), reg_data_t (logic [DATA_W-1:0]).
//  Sub-module rr_pick: req vector + rr_ptr -> one-hot gnt + encoded index.
//  Top: rr_ptr register, addr select, zero-index override, response registers.
// TESTING
//  1 reset: reset=1 two cycles with req=4'b1111 -> gnt=0, rsp_valid=0, rd_sel=0.
//  2 round-robin: req=4'b1111 held, addr {3,2,1,0}={9,7,5,3} -> gnt 0001,0010,0100,1000,
//    0001; rsp_id 0,1,2,3 one cycle later, rsp_data = reg[3],reg[5],reg[7],reg[9].
//  3 wrap/skip: rr_ptr=3, req=4'b0101 -> gnt=0001 (slot 0), then rr_ptr=1 -> gnt=0100.
//  4 zero reg: req[1]=1 addr=31, rd_data=64'hDEAD_BEEF -> next cycle rsp_valid=1,
//    rsp_id=1, rsp_data=0.
//  5 stall: grant slot 2 at T, stall=1 at T+1..T+3 with req=4'b1011 -> rsp_valid=1 at
//    T+1 only, gnt=0 during stall, first grant after stall drops is slot 3.
//  6 reset mid-run: reset asserted the cycle slot 1 is granted -> rsp_valid=0 next
//    cycle; after release with req=4'b0010 -> gnt=0010, rsp_id=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read path.
// Index and data widths match the bit-slice mux array.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int ZERO_IDX = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// Produces a one-hot grant plus its encoded index.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters.
// Round-robin grant, mux select out, tagged response one cycle later.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ZERO_IDX = regfile_pkg::ZERO_IDX
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]          rd_sel,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               grant_ok;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    grant_ok = !reset && !stall && pick_any;
    gnt      = '0;
    rd_sel   = '0;
    if (grant_ok) begin
      gnt    = pick_gnt;
      rd_sel = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= grant_ok;
      if (grant_ok) begin
        rr_ptr <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
        rsp_id <= pick_idx;
        // XZR reads as zero whatever the mux array returns
        rsp_data <= (rd_sel == ADDR_W'(ZERO_IDX)) ? '0 : rd_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed table plus random traffic
// checked against a behavioural round-robin model.
module tb_regfile_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 0;
  logic          reset;
  logic          stall;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic [AW-1:0] rd_sel;
  logic [DW-1:0] rd_data;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;

  logic [DW-1:0] regs [32];

  int errors = 0;
  int checks = 0;

  int          m_ptr;
  logic        m_valid;
  logic [1:0]  m_id;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_gnt;

  logic [N-1:0]    p_req;
  logic [N-1:0]    p_gnt;
  logic [N*AW-1:0] p_addr;
  logic            p_rst = 1'b1;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [3:0]  rq;
    logic [19:0] ad;
    logic [3:0]  g;
    logic        v;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_sel];

  regfile_read_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rq, input int ptr);
    for (int k = 0; k < N; k++)
      if (rq[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // held request without grant must keep its address
  always @(posedge clk) begin
    if (!p_rst) begin
      for (int i = 0; i < N; i++) begin
        if (p_req[i] && !p_gnt[i] && req[i]) begin
          checks++;
          if (req_addr[i*AW +: AW] !== p_addr[i*AW +: AW]) begin
            errors++;
            $display("FAIL hold_addr slot=%0d act=%0d exp=%0d", i,
                     req_addr[i*AW +: AW], p_addr[i*AW +: AW]);
          end
        end
      end
    end
    p_req  <= req;
    p_gnt  <= m_gnt;
    p_addr <= req_addr;
    p_rst  <= reset;
  end

  task automatic step(input logic r, input logic s,
                      input logic [N-1:0] rq, input logic [N*AW-1:0] ad);
    int mg;
    logic [AW-1:0] a;
    @(negedge clk);
    reset    = r;
    stall    = s;
    req      = rq;
    req_addr = ad;
    mg = (r || s) ? -1 : pick(rq, m_ptr);
    m_gnt = (mg >= 0) ? N'(1 << mg) : '0;
    a = (mg >= 0) ? ad[mg*AW +: AW] : '0;
    #1;
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("rd_sel", 64'(rd_sel), 64'(a));
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_data = '0;
    end else begin
      m_valid = (mg >= 0);
      if (mg >= 0) begin
        m_id   = 2'(mg);
        m_data = (a == 5'd31) ? '0 : regs[a];
        m_ptr  = (mg + 1) % N;
      end
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_data", rsp_data, m_data);
  endtask

  initial begin
    logic [19:0] A, Z;
    logic [N-1:0]    rq_s;
    logic [N*AW-1:0] ad_s;
    logic            r, s;

    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    regs[31] = 64'hDEAD_BEEF;
    reset = 1; stall = 0; req = '0; req_addr = '0;
    m_ptr = 0; m_valid = 0; m_id = 0; m_data = '0; m_gnt = '0;

    A = {5'd9, 5'd7, 5'd5, 5'd3};
    Z = {5'd9, 5'd7, 5'd31, 5'd3};
    //            rst stl rq       ad gnt      v  id
    tbl.push_back('{1, 0, 4'b1111, A, 4'b0000, 0, 0});
    tbl.push_back('{1, 0, 4'b1111, A, 4'b0000, 0, 0});
    tbl.push_back('{0, 0, 4'b1111, A, 4'b0001, 1, 0});
    tbl.push_back('{0, 0, 4'b1111, A, 4'b0010, 1, 1});
    tbl.push_back('{0, 0, 4'b1111, A, 4'b0100, 1, 2});
    tbl.push_back('{0, 0, 4'b1111, A, 4'b1000, 1, 3});
    tbl.push_back('{0, 0, 4'b1111, A, 4'b0001, 1, 0});
    tbl.push_back('{0, 0, 4'b0100, A, 4'b0100, 1, 2});
    tbl.push_back('{0, 0, 4'b0101, A, 4'b0001, 1, 0});
    tbl.push_back('{0, 0, 4'b0101, A, 4'b0100, 1, 2});
    tbl.push_back('{0, 0, 4'b0010, Z, 4'b0010, 1, 1});
    tbl.push_back('{0, 0, 4'b0100, A, 4'b0100, 1, 2});
    tbl.push_back('{0, 1, 4'b1011, A, 4'b0000, 0, 2});
    tbl.push_back('{0, 1, 4'b1011, A, 4'b0000, 0, 2});
    tbl.push_back('{0, 1, 4'b1011, A, 4'b0000, 0, 2});
    tbl.push_back('{0, 0, 4'b1011, A, 4'b1000, 1, 3});
    tbl.push_back('{0, 0, 4'b0001, A, 4'b0001, 1, 0});
    tbl.push_back('{1, 0, 4'b0010, A, 4'b0000, 0, 0});
    tbl.push_back('{0, 0, 4'b0010, A, 4'b0010, 1, 1});

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].stl, tbl[k].rq, tbl[k].ad);
      chk($sformatf("tbl%0d_gnt", k), 64'(m_gnt), 64'(tbl[k].g));
      chk($sformatf("tbl%0d_v", k), 64'(rsp_valid), 64'(tbl[k].v));
      chk($sformatf("tbl%0d_id", k), 64'(rsp_id), 64'(tbl[k].id));
    end
    chk("zero_reg_data_path", 64'(regs[31]), 64'hDEAD_BEEF);

    // single requester held: granted every cycle
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 4'b1000, A);
      chk("single_req", 64'(rsp_valid), 64'd1);
    end

    rq_s = '0; ad_s = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_s[i] || m_gnt[i] || reset) begin
          rq_s[i] = ($urandom_range(0, 2) != 0);
          ad_s[i*AW +: AW] = AW'($urandom_range(0, 31));
        end
      end
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 5) == 0);
      step(r, s, rq_s, ad_s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
